// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module : mips_pkg
// Brief  : Shared types and constants for the MIPS boot-loader slice.
//          loader_state_t     - imem_loader FSM state encoding
//          LOADER_LEN_BYTES   - bytes in the big-endian frame length header
// Rev    : 1.0  initial release
// ============================================================================
package mips_pkg;

    typedef enum logic [2:0] {
        LEN_HI = 3'd0,
        LEN_LO = 3'd1,
        DATA   = 3'd2,
        DONE   = 3'd3,
        ERROR  = 3'd4
    } loader_state_t;

    localparam int LOADER_LEN_BYTES = 2;

endpackage
`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module : word_assembler
// Brief  : Packs a byte stream into big-endian 32-bit words.
//          clk, reset     - clock, async active-low reset
//          i_accept       - a byte is consumed this cycle
//          i_byte         - the byte being consumed
//          i_clear        - drop any partial word and restart at byte 0
//          o_word         - assembled word (valid with o_word_valid)
//          o_word_valid   - single-cycle pulse on the 4th byte of a word
// Rev    : 1.0  initial release
// ============================================================================
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    input  logic        i_clear,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [23:0] r_shift;
    logic [1:0]  r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= 24'd0;
            r_cnt   <= 2'd0;
        end else if (i_clear) begin
            r_shift <= 24'd0;
            r_cnt   <= 2'd0;
        end else if (i_accept) begin
            r_shift <= {r_shift[15:0], i_byte};
            r_cnt   <= r_cnt + 2'd1;   // wraps 3 -> 0 at each word boundary
        end
    end

    // The 4th byte is merged combinationally so the owner can register the
    // complete word in the same cycle the byte is accepted.
    assign o_word       = {r_shift, i_byte};
    assign o_word_valid = i_accept && !i_clear && (r_cnt == 2'd3);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module : imem_loader
// Brief  : Boot loader. Receives a length-prefixed byte image, writes it into
//          instruction memory and holds the core in reset until complete.
//          clk, reset            - clock, async active-low reset
//          byte_valid/byte_data  - byte stream in
//          byte_ready            - stream back-pressure (transfer = valid&ready)
//          imem_we/addr/wdata    - registered instruction-memory write port
//          cpu_hold              - active-high core reset, released on done
//          done / error          - terminal status
//          words_loaded          - words written so far
// Rev    : 1.0  initial release
// ============================================================================
module imem_loader
    import mips_pkg::*;
#(
    parameter int DEPTH          = 256,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);

    loader_state_t   r_state;
    loader_state_t   w_state_next;
    logic [15:0]     r_len;
    logic [15:0]     r_words;
    logic [c_TW-1:0] r_timeout;
    logic            r_we;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;

    logic            w_xfer;
    logic [15:0]     w_len_full;
    logic            w_timed_state;
    logic            w_expire;
    logic            w_last_write;
    logic [31:0]     w_word;
    logic            w_word_valid;

    assign w_xfer        = byte_valid && byte_ready;
    assign w_len_full    = {r_len[15:8], byte_data};
    assign w_timed_state = (r_state == LEN_LO) || (r_state == DATA);
    // Counter about to reach the limit with no transfer arriving; a transfer
    // in the same cycle always wins.
    assign w_expire      = w_timed_state && !w_xfer &&
                           (r_timeout == c_TW'(TIMEOUT_CYCLES - 1));
    assign w_last_write  = r_we && (r_words == (r_len - 16'd1));

    word_assembler u_word_assembler (
        .clk          (clk),
        .reset        (reset),
        .i_accept     (w_xfer && (r_state == DATA)),
        .i_byte       (byte_data),
        .i_clear      (r_state != DATA),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= LEN_HI;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LEN_HI: if (w_xfer) w_state_next = LEN_LO;
            LEN_LO: begin
                if (w_xfer) begin
                    if (w_len_full == 16'd0)                  w_state_next = DONE;
                    else if ({16'd0, w_len_full} > 32'(DEPTH)) w_state_next = ERROR;
                    else                                       w_state_next = DATA;
                end else if (w_expire) begin
                    w_state_next = ERROR;
                end
            end
            // Leave DATA only after the final word's write strobe has issued.
            DATA: begin
                if (w_last_write)  w_state_next = DONE;
                else if (w_expire) w_state_next = ERROR;
            end
            default: w_state_next = r_state;   // DONE / ERROR are terminal
        endcase
    end

    // ---------------- counters and write port ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len     <= 16'd0;
            r_words   <= 16'd0;
            r_timeout <= '0;
            r_we      <= 1'b0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
        end else begin
            if (w_xfer && (r_state == LEN_HI)) r_len[15:8] <= byte_data;
            if (w_xfer && (r_state == LEN_LO)) r_len[7:0]  <= byte_data;

            if (!w_timed_state || w_xfer) r_timeout <= '0;
            else if (!w_expire)           r_timeout <= r_timeout + c_TW'(1);

            r_we <= w_word_valid;
            if (w_word_valid) begin
                r_addr  <= {14'd0, r_words, 2'b00};
                r_wdata <= w_word;
            end

            if (r_we) r_words <= r_words + 16'd1;
        end
    end

    assign byte_ready   = (r_state != DONE);
    assign cpu_hold     = (r_state != DONE);
    assign done         = (r_state == DONE);
    assign error        = (r_state == ERROR);
    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign words_loaded = r_words;

endmodule
`default_nettype wire
